// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, response FSM states and lane helpers for the block RAM responder.
// Declarations only: no latency, no backpressure of its own.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } resp_state_t;

    // Write captured in its address phase, consumed in its data phase.
    typedef struct packed {
        logic       pend;
        logic [3:0] mask;
    } wr_meta_t;

    // Per byte lane: take fwd where sel is set, otherwise the RAM word.
    function automatic logic [31:0] lane_merge(input logic [31:0] fwd,
                                               input logic [31:0] ram,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = ram;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = fwd[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Maps transfer size and low address bits to RAM byte-lane enables and flags misaligned/oversized transfers.
// Purely combinational (zero latency); no backpressure.
module ahb_byte_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << haddr_lo;
            HSIZE_HALF: begin
                illegal = haddr_lo[0];
                mask    = haddr_lo[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                illegal = |haddr_lo;
                mask    = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
        // An illegal transfer must never reach the RAM write strobes.
        if (illegal) begin
            mask = 4'b0000;
        end
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite responder for the M0 byte-write dual-port block RAM: zero-wait reads/writes, two-cycle ERROR.
// Read data one cycle after the address phase; only stalls itself for ERROR, holds its data phase while hready=0.
module ahb_bram_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [3:0]            bram_wea,
    output logic [31:0]           bram_dina,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    logic [3:0]            lane_mask;
    logic                  lane_illegal;
    logic                  xfer_vld;
    logic                  xfer_ok;
    logic                  xfer_err;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic                  wr_dphase;
    logic                  fwd_hit;
    logic                  haddr_unused;

    wr_meta_t              wr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  rd_pend_q;
    logic                  fwd_vld_q;
    logic [3:0]            fwd_mask_q;
    logic [31:0]           fwd_dat_q;

    resp_state_t           state_q;
    resp_state_t           state_d;

    ahb_byte_lane_decode u_lane_decode (
        .hsize    (hsize),
        .haddr_lo (haddr[1:0]),
        .mask     (lane_mask),
        .illegal  (lane_illegal)
    );

    // Bits above the RAM window alias silently.
    assign haddr_unused = ^haddr[31:ADDR_WIDTH+2];
    assign addr_word    = haddr[ADDR_WIDTH+1:2];

    assign xfer_vld = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
    assign xfer_ok  = xfer_vld & ~lane_illegal;
    assign xfer_err = xfer_vld & lane_illegal;

    // The RAM returns stale data when read and written in the same cycle,
    // so a same-word read address phase snoops the write data phase instead.
    assign wr_dphase = wr_q.pend & hready & ~rst;
    assign fwd_hit   = xfer_ok & ~hwrite & wr_q.pend & (wr_addr_q == addr_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            wr_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            fwd_vld_q  <= 1'b0;
            fwd_mask_q <= 4'b0000;
            fwd_dat_q  <= 32'h0;
        end else if (hready) begin
            wr_q.pend <= xfer_ok & hwrite;
            wr_q.mask <= lane_mask;
            wr_addr_q <= addr_word;
            rd_pend_q <= xfer_ok & ~hwrite;
            fwd_vld_q <= fwd_hit;
            if (fwd_hit) begin
                fwd_mask_q <= wr_q.mask;
                fwd_dat_q  <= hwdata;
            end
        end
    end

    assign bram_addra = wr_addr_q;
    assign bram_dina  = hwdata;
    assign bram_wea   = wr_dphase ? wr_q.mask : 4'b0000;
    assign bram_addrb = addr_word;

    assign hrdata = rd_pend_q ? lane_merge(fwd_dat_q, bram_doutb, fwd_vld_q ? fwd_mask_q : 4'b0000)
                              : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OKAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            OKAY: begin
                if (xfer_err) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                hresp   = 1'b1;
                state_d = xfer_err ? ERR1 : OKAY;
            end
            default: state_d = OKAY;
        endcase
    end

endmodule
